// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular transmit FIFO.
// Frames go out back-to-back; parity and stop-bit settings are captured per frame at pop time.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [DATA_BITS-1:0]        s_data,
    output logic                        s_ready,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    output logic                        tx_line,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_count;
    logic [AW:0]          w_count_next;
    logic                 r_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_nonempty;
    logic [DATA_BITS-1:0] w_head;

    state_t               r_state;
    state_t               w_state_next;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_par_en;
    logic                 r_two_stop;
    logic                 r_tx;
    logic                 r_busy;
    logic                 w_tx_next;
    logic                 w_baud_end;
    logic                 w_last_data;
    logic                 w_stop_done;

    assign s_ready    = r_ready;
    assign tx_line    = r_tx;
    assign tx_busy    = r_busy;
    assign fifo_count = r_count;

    assign w_push      = s_valid && r_ready;
    assign w_nonempty  = (r_count != '0);
    assign w_head      = r_mem[r_rptr];
    assign w_baud_end  = (r_baud == CW'(DIV - 1));
    assign w_last_data = (r_bitcnt == BW'(DATA_BITS - 1));
    assign w_stop_done = !r_two_stop || (r_bitcnt == BW'(1));

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= s_data;
        end
    end

    // Ready tracks the post-edge occupancy so a full FIFO never sees an extra push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != (AW + 1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // tx_line is computed one edge ahead so the line itself comes straight from a flop.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (w_nonempty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (!w_last_data) begin
                        w_tx_next = r_shift[1];
                    end else if (r_par_en) begin
                        w_state_next = S_PARITY;
                        w_tx_next    = r_par_bit;
                    end else begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_end) begin
                    w_state_next = S_STOP;
                    w_tx_next    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end && w_stop_done) begin
                    if (w_nonempty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_baud     <= '0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= (w_state_next != S_IDLE);

            if (w_pop || w_baud_end || (r_state == S_IDLE)) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + CW'(1);
            end

            if (w_pop || (w_baud_end && (w_state_next != r_state))) begin
                r_bitcnt <= '0;
            end else if (w_baud_end) begin
                r_bitcnt <= r_bitcnt + BW'(1);
            end

            if (w_pop) begin
                r_shift    <= w_head;
                r_par_bit  <= (^w_head) ^ (parity_mode == 2'b10);
                r_par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                r_two_stop <= two_stop;
            end else if ((r_state == S_DATA) && w_baud_end) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected frames, a line monitor
// decodes tx_line bit by bit and compares each frame against the queue head.
module tb_uart_tx_fifo;
    localparam int unsigned DIV = 16;

    typedef struct {
        logic [15:0] bits;
        int unsigned len;
        bit          follow;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready;
    logic [1:0] parity_mode = 2'b00;
    logic       two_stop = 1'b0;
    logic       tx8;
    logic       busy8;
    logic [4:0] count8;

    logic       s_valid7 = 1'b0;
    logic [6:0] s_data7 = '0;
    logic       s_ready7;
    logic       tx7;
    logic       busy7;
    logic [4:0] count7;

    logic       sel7 = 1'b0;
    logic       mon_en = 1'b1;
    logic       mon_busy = 1'b0;
    logic       expect_start = 1'b0;
    logic       mon_line;
    logic       busy_prev = 1'b0;

    frame_t     exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         busy_rises = 0;
    int         busy_clks = 0;

    always #5 clk = ~clk;

    assign mon_line = sel7 ? tx7 : tx8;

    uart_tx_fifo #(
        .CLK_FREQ  (1_600_000),
        .BAUD_RATE (100_000),
        .DATA_BITS (8),
        .FIFO_DEPTH(16)
    ) dut8 (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .tx_line    (tx8),
        .tx_busy    (busy8),
        .fifo_count (count8)
    );

    uart_tx_fifo #(
        .CLK_FREQ  (1_600_000),
        .BAUD_RATE (100_000),
        .DATA_BITS (7),
        .FIFO_DEPTH(16)
    ) dut7 (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid7),
        .s_data     (s_data7),
        .s_ready    (s_ready7),
        .parity_mode(parity_mode),
        .two_stop   (two_stop),
        .tx_line    (tx7),
        .tx_busy    (busy7),
        .fifo_count (count7)
    );

    function automatic frame_t mk(input logic [15:0] bits, input int unsigned len, input bit follow);
        frame_t f;
        f.bits   = bits;
        f.len    = len;
        f.follow = follow;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push8(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy || busy8 || busy7) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_within_budget", 32'(n < 6000), 1);
        @(negedge clk);
    endtask

    initial begin : busy_counter
        forever begin
            @(negedge clk);
            if (busy8 && !busy_prev) busy_rises++;
            if (busy8) busy_clks++;
            busy_prev = busy8;
        end
    end

    initial begin : monitor
        frame_t      f;
        logic [15:0] got;
        bit          stable;
        forever begin
            @(negedge clk);
            if (expect_start) begin
                checks++;
                if (mon_line !== 1'b0) begin
                    errors++;
                    $display("FAIL interframe_gap: line %b expected 0 (start bit)", mon_line);
                end
                expect_start = 1'b0;
            end
            if (mon_en && mon_line === 1'b0) begin
                mon_busy = 1'b1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start: start bit with empty scoreboard");
                    for (int k = 0; k < 300 && mon_line === 1'b0; k++) @(negedge clk);
                end else begin
                    f      = exp_q.pop_front();
                    got    = '0;
                    stable = 1'b1;
                    for (int b = 0; b < int'(f.len); b++) begin
                        for (int j = 0; j < int'(DIV); j++) begin
                            if (b != 0 || j != 0) @(negedge clk);
                            if (j == 0) got[b] = mon_line;
                            else if (mon_line !== got[b]) stable = 1'b0;
                        end
                    end
                    checks++;
                    if (got !== f.bits) begin
                        errors++;
                        $display("FAIL frame_bits: got %b expected %b", got, f.bits);
                    end
                    if (!stable) begin
                        errors++;
                        $display("FAIL bit_stability: line changed inside a bit period in frame %b", f.bits);
                    end
                    expect_start = f.follow;
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int   idx;
        int   low_cnt;
        int   guard;
        int   lows;
        int   busy_seen;
        logic rdy;
        logic drop_seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_line", 32'(tx8), 1);
        chk("rst_tx_busy", 32'(busy8), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_fifo_count", 32'(count8), 0);
        rst  = 1'b0;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx8 !== 1'b1) lows++;
        end
        chk("idle_no_toggle", 32'(lows), 0);

        busy_rises = 0;
        busy_clks  = 0;
        exp_q.push_back(mk(16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0));
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        s_valid     = 1'b1;
        s_data      = 8'hA5;
        @(negedge clk);
        s_valid = 1'b0;
        chk("lat_tx_after_accept", 32'(tx8), 1);
        chk("lat_count_after_accept", 32'(count8), 1);
        @(negedge clk);
        chk("lat_tx_after_pop", 32'(tx8), 0);
        chk("lat_busy_after_pop", 32'(busy8), 1);
        chk("lat_count_after_pop", 32'(count8), 0);
        wait_drain();
        chk("busy_clks_none_1stop", 32'(busy_clks), 160);

        busy_clks   = 0;
        parity_mode = 2'b01;
        exp_q.push_back(mk(16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 1'b0));
        push8(8'hA5);
        repeat (50) @(negedge clk);
        parity_mode = 2'b10;
        wait_drain();
        chk("busy_clks_even_1stop", 32'(busy_clks), 176);

        busy_clks   = 0;
        parity_mode = 2'b10;
        two_stop    = 1'b1;
        exp_q.push_back(mk(16'({2'b11, 1'b1, 8'hA5, 1'b0}), 12, 1'b0));
        push8(8'hA5);
        repeat (2) @(negedge clk);
        two_stop    = 1'b0;
        parity_mode = 2'b00;
        wait_drain();
        chk("busy_clks_odd_2stop", 32'(busy_clks), 192);

        for (int i = 0; i < 18; i++) begin
            exp_q.push_back(mk(16'({1'b1, 8'(i), 1'b0}), 10, (i < 17)));
        end
        busy_clks  = 0;
        busy_rises = 0;
        idx        = 0;
        low_cnt    = 0;
        guard      = 0;
        drop_seen  = 1'b0;
        s_data     = 8'h00;
        s_valid    = 1'b1;
        while (idx < 18 && guard < 3000) begin
            rdy = s_ready;
            if (!rdy) begin
                if (!drop_seen) begin
                    drop_seen = 1'b1;
                    chk("accepted_before_full", 32'(idx), 17);
                    chk("count_at_full", 32'(count8), 16);
                end
                low_cnt++;
            end
            @(negedge clk);
            guard++;
            if (rdy) begin
                idx++;
                s_data = 8'(idx);
            end
        end
        s_valid = 1'b0;
        chk("burst_all_accepted", 32'(idx), 18);
        chk("ready_dropped", 32'(drop_seen), 1);
        chk("ready_low_clocks", 32'(low_cnt), 145);
        wait_drain();
        chk("burst_busy_rises", 32'(busy_rises), 1);
        chk("burst_busy_clks", 32'(busy_clks), 2880);

        sel7 = 1'b1;
        exp_q.push_back(mk(16'({1'b1, 7'h55, 1'b0}), 9, 1'b0));
        s_valid7 = 1'b1;
        s_data7  = 7'h55;
        @(negedge clk);
        s_valid7 = 1'b0;
        wait_drain();
        sel7 = 1'b0;

        mon_en  = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hEF;
        @(negedge clk);
        s_data = 8'h12;
        @(negedge clk);
        s_data = 8'h34;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (87) @(negedge clk);
        chk("midframe_data_bit4", 32'(tx8), 0);
        chk("midframe_count", 32'(count8), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx_line", 32'(tx8), 1);
        chk("midrst_fifo_count", 32'(count8), 0);
        chk("midrst_tx_busy", 32'(busy8), 0);
        chk("midrst_s_ready", 32'(s_ready), 1);
        rst       = 1'b0;
        lows      = 0;
        busy_seen = 0;
        repeat (600) begin
            @(negedge clk);
            if (tx8 !== 1'b1) lows++;
            if (busy8 !== 1'b0) busy_seen++;
        end
        chk("post_rst_no_start", 32'(lows), 0);
        chk("post_rst_no_busy", 32'(busy_seen), 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
